uart_tx_fifo_drain: RTL and testbench
=====================================

// Module: uart_tx_fifo_drain
// PURPOSE
//  UART transmit serializer that sits directly downstream of the TX FIFO read side, in the read clock domain.
//  - Watches the FIFO empty flag and pops one byte with a single-cycle rinc pulse.
//  - Frames the byte as start, DATA_WIDTH data bits (LSB first), optional parity, and stop, then drives it on tx_out.
//  - Drains the FIFO back-to-back with no idle gap between frames while data remains.
// PARAMETERS
//  DATA_WIDTH    8   width of FIFO read data / serialized payload
//  CLKS_PER_BIT  16  rclk cycles per UART bit period; legal values >= 2
// PORTS
//  rclk      in   1           read-domain clock; the only clock
//  rrst      in   1           reset, synchronous to rclk, active-high
//  empty     in   1           FIFO empty flag (1 = no data available)
//  rdata     in   DATA_WIDTH  FIFO read data at the current read address; valid in the same cycle (asynchronous memory read)
//  rinc      out  1           FIFO pop/read-increment request, one cycle per byte
//  par_en    in   1           1 = insert a parity bit
//  par_typ   in   1           0 = even parity, 1 = odd parity
//  tx_out    out  1           serial line output, idles high
//  busy      out  1           1 while a frame is on the line (START through STOP)
// BEHAVIOUR
//  - Reset (rrst=1 at a rclk edge):
//    - state=IDLE; tx_out=1; busy=0; rinc=0; baud and bit counters=0.
//    - The reset has priority over every other event.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//  - Pop rule: rinc = (IDLE & !empty) | (last STOP cycle & !empty), combinational.
//    - rinc is never 1 while empty=1.
//    - rinc is never 1 for more than one cycle per byte.
//  - On every cycle with rinc=1:
//    - Capture rdata into the shift register.
//    - Latch par_en and par_typ.
//    - Compute parity = ^rdata ^ par_typ.
//    - Next state is START.
//    - par_en/par_typ changes mid-frame have no effect on the current frame.
//  - Latency: rinc high at edge N, so tx_out=0 (start bit) from edge N+1. tx_out and busy are registered.
//  - Timing: every bit is held for exactly CLKS_PER_BIT cycles.
//    - The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
//  - START: tx_out=0, then go to DATA with bit counter=0.
//  - DATA: tx_out=shift[0], shifting right at each bit boundary.
//    - After bit DATA_WIDTH-1, go to PARITY if par_en, else to STOP.
//    - The bit counter is $clog2(DATA_WIDTH) bits wide and never exceeds DATA_WIDTH-1.
//  - PARITY: tx_out = the latched parity bit, then go to STOP.
//  - STOP: tx_out=1.
//    - On the last cycle, if !empty: pop and go to START, with zero idle gap and busy staying 1.
//    - Otherwise go to IDLE and busy=0 from the next cycle.
//  - Frame length: (2 + DATA_WIDTH + par_en) * CLKS_PER_BIT cycles exactly.
//  - Empty flag:
//    - empty rising mid-frame does not affect the current frame.
//    - empty falling mid-frame is acted on only at the last STOP cycle.
//  - Reset mid-frame: tx_out=1 and busy=0 from the next edge. The popped byte is discarded and not re-popped.
//  - IDLE & empty: tx_out=1, busy=0, rinc=0 indefinitely.
// TESTING (DATA_WIDTH=8, CLKS_PER_BIT=4)
//  1. Hold rrst=1 for 2 cycles with empty=0.
//     -> rinc=0, tx_out=1, busy=0 during reset; first rinc in the cycle after rrst falls.
//  2. Send 0xA5 with par_en=0 and empty falling for one byte.
//     -> Exactly one rinc pulse.
//     -> tx_out bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles.
//     -> busy high for exactly 40 cycles.
//  3. Send 0x07 with par_en=1.
//     -> par_typ=0: parity bit=1; par_typ=1: parity bit=0.
//     -> Frame is 44 cycles either way.
//  4. Send 0x55 then 0xAA with empty held low.
//     -> Second rinc on the last STOP cycle of frame 1.
//     -> Start bit of frame 2 follows immediately.
//     -> busy high for 80 continuous cycles.
//  5. Hold empty=1 for 100 cycles.
//     -> rinc never asserted, tx_out=1, busy=0 throughout.
//  6. Pulse rrst during DATA bit 3.
//     -> tx_out=1 and busy=0 next cycle.
//     -> The next rinc occurs only from IDLE with empty=0.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// UART transmit serializer that drains a TX FIFO read port back-to-back.
// Frame: start, DATA_WIDTH data bits LSB first, optional parity, stop; tx_out idles high.
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [BAUD_W-1:0]     baud_cnt, baud_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_bit, par_bit_nxt;
  logic                  tx_nxt, busy_nxt;
  logic                  bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // A pop happens from IDLE or on the final STOP cycle, which gives gap-free draining.
  assign rinc = !rrst && !empty && ((state == IDLE) || ((state == STOP) && bit_end));

  always_comb begin
    state_nxt   = state;
    baud_nxt    = ((state == IDLE) || bit_end) ? '0 : baud_cnt + 1'b1;
    bit_nxt     = bit_cnt;
    shift_nxt   = shift;
    par_en_nxt  = par_en_q;
    par_bit_nxt = par_bit;
    tx_nxt      = 1'b1;
    busy_nxt    = 1'b0;

    if (rinc) begin
      shift_nxt   = rdata;
      par_en_nxt  = par_en;
      par_bit_nxt = ^rdata ^ par_typ;
      baud_nxt    = '0;
      state_nxt   = START;
    end else begin
      case (state)
        START: begin
          if (bit_end) begin
            state_nxt = DATA;
            bit_nxt   = '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_nxt = shift >> 1;
            if (bit_cnt == BIT_LAST) state_nxt = par_en_q ? PARITY : STOP;
            else                     bit_nxt   = bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) state_nxt = STOP;
        end
        STOP: begin
          if (bit_end) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par_bit_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      par_en_q <= par_en_nxt;
      par_bit  <= par_bit_nxt;
      tx_out   <= tx_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: a frame-timeline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo_drain;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          empty = 1'b0;
  logic [DW-1:0] rdata = 8'hA5;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          rinc, tx_out, busy;

  int total = 0;
  int bad   = 0;
  int rinc_cnt = 0, busy_cnt = 0, txlow_cnt = 0;
  logic cap [0:63];

  always #5 rclk = ~rclk;

  uart_tx_fifo_drain #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .rclk(rclk), .rrst(rrst), .empty(empty), .rdata(rdata), .rinc(rinc),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx_out), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a frame is a list of bits; the line shows bit (cycle / CPB) while active.
  bit   m_active = 1'b0;
  int   m_cyc = 0;
  int   m_len = 0;
  logic m_bits [0:15];

  function automatic logic model_rinc();
    return !rrst && !empty && (!m_active || (m_cyc == m_len - 1));
  endfunction

  always @(posedge rclk) begin
    logic pop;
    int   ones;
    int   nb;
    pop = model_rinc();
    if (rrst) begin
      m_active = 1'b0;
    end else if (pop) begin
      ones = 0;
      m_bits[0] = 1'b0;
      for (int i = 0; i < DW; i++) begin
        m_bits[1+i] = rdata[i];
        ones += int'(rdata[i]);
      end
      nb = 1 + DW;
      if (par_en) begin
        m_bits[nb] = par_typ ? ((ones % 2) == 0) : ((ones % 2) == 1);
        nb++;
      end
      m_bits[nb] = 1'b1;
      m_len = (nb + 1) * CPB;
      m_cyc = 0;
      m_active = 1'b1;
    end else if (m_active) begin
      m_cyc++;
      if (m_cyc == m_len) m_active = 1'b0;
    end
  end

  always @(negedge rclk) begin
    checkOutput("model_rinc", rinc, model_rinc());
    checkOutput("model_busy", busy, m_active);
    checkOutput("model_tx", tx_out, m_active ? m_bits[m_cyc / CPB] : 1'b1);
    if (rinc) rinc_cnt++;
    if (busy) busy_cnt++;
    if (!tx_out) txlow_cnt++;
  end

  task automatic clear_counts();
    rinc_cnt = 0;
    busy_cnt = 0;
    txlow_cnt = 0;
  endtask

  task automatic wait_rinc();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge rclk);
      got = rinc;
    end
    checkOutput("rinc_seen", got, 1);
  endtask

  task automatic capture_frame(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge rclk);
      cap[i] = tx_out;
    end
  endtask

  // One isolated frame; par_en/par_typ are flipped mid-frame and must be ignored.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic pe, input logic pt);
    @(posedge rclk); #1;
    rdata = d; par_en = pe; par_typ = pt; empty = 1'b0;
    clear_counts();
    wait_rinc();
    @(posedge rclk); #1;
    empty = 1'b1; par_en = ~pe; par_typ = ~pt;
    capture_frame(44);
    repeat (8) @(negedge rclk);
  endtask

  initial begin
    logic [9:0] a5_bits;
    a5_bits = 10'b1101001010;

    // Reset held for two edges with data waiting.
    @(negedge rclk);
    checkOutput("rst_rinc", rinc, 0);
    checkOutput("rst_tx", tx_out, 1);
    checkOutput("rst_busy", busy, 0);
    @(posedge rclk); #1;
    rrst = 1'b0;
    clear_counts();
    @(negedge rclk);
    checkOutput("first_rinc_after_rst", rinc, 1);

    // 0xA5 without parity.
    @(posedge rclk); #1;
    empty = 1'b1;
    capture_frame(40);
    repeat (10) @(negedge rclk);
    checkOutput("a5_rinc_count", rinc_cnt, 1);
    checkOutput("a5_busy_cycles", busy_cnt, 40);
    for (int i = 0; i < 10; i++) checkOutput($sformatf("a5_bit%0d", i), cap[i*CPB+2], a5_bits[i]);

    // 0x07 with even then odd parity.
    applyStimulus(8'h07, 1'b1, 1'b0);
    checkOutput("p_even_bit", cap[9*CPB+2], 1);
    checkOutput("p_even_stop", cap[10*CPB+2], 1);
    checkOutput("p_even_busy", busy_cnt, 44);
    applyStimulus(8'h07, 1'b1, 1'b1);
    checkOutput("p_odd_bit", cap[9*CPB+2], 0);
    checkOutput("p_odd_busy", busy_cnt, 44);
    checkOutput("p_odd_rinc_count", rinc_cnt, 1);

    // 0x55 then 0xAA back-to-back.
    @(posedge rclk); #1;
    rdata = 8'h55; par_en = 1'b0; empty = 1'b0;
    clear_counts();
    wait_rinc();
    @(posedge rclk); #1;
    rdata = 8'hAA;
    for (int i = 1; i <= 40; i++) begin
      @(negedge rclk);
      if (i == 39) checkOutput("b2b_no_early_rinc", rinc_cnt, 1);
      if (i == 40) checkOutput("b2b_rinc_last_stop", rinc, 1);
    end
    @(posedge rclk); #1;
    empty = 1'b1;
    @(negedge rclk);
    checkOutput("b2b_start_tx", tx_out, 0);
    checkOutput("b2b_start_busy", busy, 1);
    repeat (48) @(negedge rclk);
    checkOutput("b2b_rinc_count", rinc_cnt, 2);
    checkOutput("b2b_busy_cycles", busy_cnt, 80);

    // Empty held for 100 cycles.
    @(posedge rclk); #1;
    clear_counts();
    repeat (100) @(negedge rclk);
    checkOutput("empty_rinc", rinc_cnt, 0);
    checkOutput("empty_busy", busy_cnt, 0);
    checkOutput("empty_txlow", txlow_cnt, 0);

    // Reset pulse during data bit 3, then resume from IDLE.
    @(posedge rclk); #1;
    rdata = 8'h3C; empty = 1'b0;
    wait_rinc();
    @(posedge rclk); #1;
    empty = 1'b1;
    repeat (18) @(negedge rclk);
    @(posedge rclk); #1;
    rrst = 1'b1;
    @(posedge rclk); #1;
    rrst = 1'b0;
    clear_counts();
    @(negedge rclk);
    checkOutput("midrst_tx", tx_out, 1);
    checkOutput("midrst_busy", busy, 0);
    repeat (10) @(negedge rclk);
    checkOutput("midrst_no_repop", rinc_cnt, 0);
    @(posedge rclk); #1;
    rdata = 8'h81; empty = 1'b0;
    wait_rinc();
    checkOutput("midrst_pop_from_idle_busy", busy, 0);
    @(posedge rclk); #1;
    empty = 1'b1;
    capture_frame(40);
    repeat (8) @(negedge rclk);
    checkOutput("midrst_resume_busy", busy_cnt, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
